// File: rtl/axis_sched_pkg.sv
// Shared definitions for the accelerometer sample scheduler: FSM encoding,
// default parameter values and small datapath helpers.
package axis_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_X = 3'd1,
        ST_RD_Y = 3'd2,
        ST_PUB  = 3'd3,
        ST_HOLD = 3'd4
    } sched_state_e;

    localparam logic [5:0] DEF_ADDR_X      = 6'h32;
    localparam logic [5:0] DEF_ADDR_Y      = 6'h34;
    localparam int         DEF_TICK_DIV    = 50000;
    localparam int         DEF_PULSE_W     = 4;
    localparam int         DEF_TIMEOUT_CYC = 1024;

    // Samples are left-justified; the LED path only needs the top ten bits.
    function automatic logic [9:0] sample_msb10(input logic [15:0] raw);
        return raw[15:6];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? 8'hFF : val + 8'd1;
    endfunction

endpackage

// File: rtl/axis_sample_scheduler_tick_gen.sv
// Sample-period generator: one-cycle tick every TICK_DIV cycles while enabled.
module tick_gen
    import axis_sched_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iEN,
    output logic oTICK
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_r;

    // Period counter; held at zero while disabled so re-enable restarts a full period.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt_r <= {CW{1'b0}};
            oTICK <= 1'b0;
        end else if (!iEN) begin
            cnt_r <= {CW{1'b0}};
            oTICK <= 1'b0;
        end else if (cnt_r == CW'(TICK_DIV - 1)) begin
            cnt_r <= {CW{1'b0}};
            oTICK <= 1'b1;
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            oTICK <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_sample_scheduler.sv
// Periodic X/Y SPI sampler publishing one axis to the LED driver with a low
// strobe on oG_INT2. Define SAMPLE_TIMEOUT_EN to abandon requests left unacknowledged.
module axis_sample_scheduler
    import axis_sched_pkg::*;
#(
    parameter int         TICK_DIV    = DEF_TICK_DIV,
    parameter int         PULSE_W     = DEF_PULSE_W,
    parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter logic [5:0] ADDR_X      = DEF_ADDR_X,
    parameter logic [5:0] ADDR_Y      = DEF_ADDR_Y
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEN,
    input  logic        iAXIS_SEL,
    output logic        oSPI_REQ,
    output logic [5:0]  oSPI_ADDR,
    input  logic        iSPI_ACK,
    input  logic [15:0] iSPI_DATA,
    output logic [9:0]  oDIG,
    output logic        oG_INT2,
    output logic        oBUSY,
    output logic        oOVR,
    output logic [7:0]  oTO_CNT
);

    localparam int PW_W = $clog2(PULSE_W + 1);

    sched_state_e    state_r;
    logic [9:0]      x_hold_r;
    logic [9:0]      y_hold_r;
    logic [PW_W-1:0] hold_cnt_r;
    logic            tick_s;
`ifdef SAMPLE_TIMEOUT_EN
    localparam int WT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WT_W-1:0] wait_cnt_r;
`endif

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iEN   (iEN),
        .oTICK (tick_s)
    );

    // Sequencer: oBUSY is updated alongside every state change so it mirrors state != IDLE.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r    <= ST_IDLE;
            x_hold_r   <= 10'h000;
            y_hold_r   <= 10'h000;
            hold_cnt_r <= {PW_W{1'b0}};
            oSPI_REQ   <= 1'b0;
            oSPI_ADDR  <= 6'h00;
            oDIG       <= 10'h000;
            oG_INT2    <= 1'b1;
            oBUSY      <= 1'b0;
            oOVR       <= 1'b0;
            oTO_CNT    <= 8'h00;
`ifdef SAMPLE_TIMEOUT_EN
            wait_cnt_r <= {WT_W{1'b0}};
`endif
        end else begin
            // Ticks landing in any non-idle state, including the last HOLD cycle, are dropped.
            if (tick_s && (state_r != ST_IDLE)) begin
                oOVR <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (tick_s) begin
                        state_r   <= ST_RD_X;
                        oSPI_REQ  <= 1'b1;
                        oSPI_ADDR <= ADDR_X;
                        oBUSY     <= 1'b1;
`ifdef SAMPLE_TIMEOUT_EN
                        wait_cnt_r <= {WT_W{1'b0}};
`endif
                    end
                end
                ST_RD_X: begin
                    if (iSPI_ACK) begin
                        x_hold_r <= sample_msb10(iSPI_DATA);
                        oSPI_REQ <= 1'b0;
                        state_r  <= ST_RD_Y;
                    end
`ifdef SAMPLE_TIMEOUT_EN
                    else if (wait_cnt_r == WT_W'(TIMEOUT_CYC - 1)) begin
                        oSPI_REQ <= 1'b0;
                        oBUSY    <= 1'b0;
                        oTO_CNT  <= sat_inc8(oTO_CNT);
                        state_r  <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + {{(WT_W-1){1'b0}}, 1'b1};
                    end
`endif
                end
                ST_RD_Y: begin
                    // One idle cycle separates the two requests so the slave sees a fresh rising REQ.
                    if (!oSPI_REQ) begin
                        oSPI_REQ  <= 1'b1;
                        oSPI_ADDR <= ADDR_Y;
`ifdef SAMPLE_TIMEOUT_EN
                        wait_cnt_r <= {WT_W{1'b0}};
`endif
                    end else if (iSPI_ACK) begin
                        y_hold_r <= sample_msb10(iSPI_DATA);
                        oSPI_REQ <= 1'b0;
                        state_r  <= ST_PUB;
                    end
`ifdef SAMPLE_TIMEOUT_EN
                    else if (wait_cnt_r == WT_W'(TIMEOUT_CYC - 1)) begin
                        oSPI_REQ <= 1'b0;
                        oBUSY    <= 1'b0;
                        oTO_CNT  <= sat_inc8(oTO_CNT);
                        state_r  <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + {{(WT_W-1){1'b0}}, 1'b1};
                    end
`endif
                end
                ST_PUB: begin
                    oDIG       <= iAXIS_SEL ? y_hold_r : x_hold_r;
                    oG_INT2    <= 1'b0;
                    hold_cnt_r <= {PW_W{1'b0}};
                    state_r    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt_r == PW_W'(PULSE_W - 1)) begin
                        oG_INT2 <= 1'b1;
                        oBUSY   <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + {{(PW_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    oSPI_REQ <= 1'b0;
                    oG_INT2  <= 1'b1;
                    oBUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_sample_scheduler.sv
// Directed bench for axis_sample_scheduler (TICK_DIV=8, PULSE_W=2, TIMEOUT_CYC=16).
module tb_axis_sample_scheduler;

    localparam int TICK_DIV    = 8;
    localparam int PULSE_W     = 2;
    localparam int TIMEOUT_CYC = 16;

    logic        iCLK      = 1'b0;
    logic        iRST      = 1'b1;
    logic        iEN       = 1'b0;
    logic        iAXIS_SEL = 1'b0;
    logic        iSPI_ACK  = 1'b0;
    logic [15:0] iSPI_DATA = 16'h0000;
    logic        oSPI_REQ;
    logic [5:0]  oSPI_ADDR;
    logic [9:0]  oDIG;
    logic        oG_INT2;
    logic        oBUSY;
    logic        oOVR;
    logic [7:0]  oTO_CNT;

    int   checks   = 0;
    int   failures = 0;
    int   falls    = 0;
    int   base     = 0;
    logic g_prev   = 1'b1;

    axis_sample_scheduler #(
        .TICK_DIV    (TICK_DIV),
        .PULSE_W     (PULSE_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .ADDR_X      (6'h32),
        .ADDR_Y      (6'h34)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iEN       (iEN),
        .iAXIS_SEL (iAXIS_SEL),
        .oSPI_REQ  (oSPI_REQ),
        .oSPI_ADDR (oSPI_ADDR),
        .iSPI_ACK  (iSPI_ACK),
        .iSPI_DATA (iSPI_DATA),
        .oDIG      (oDIG),
        .oG_INT2   (oG_INT2),
        .oBUSY     (oBUSY),
        .oOVR      (oOVR),
        .oTO_CNT   (oTO_CNT)
    );

    always #5 iCLK = ~iCLK;

    // Count strobe falling edges, sampled mid-cycle.
    always @(negedge iCLK) begin
        if (g_prev && !oG_INT2) falls = falls + 1;
        g_prev = oG_INT2;
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},  16'(oSPI_REQ),  16'h0);
        chk({tag, "_addr"}, 16'(oSPI_ADDR), 16'h0);
        chk({tag, "_dig"},  16'(oDIG),      16'h0);
        chk({tag, "_int2"}, 16'(oG_INT2),   16'h1);
        chk({tag, "_busy"}, 16'(oBUSY),     16'h0);
        chk({tag, "_ovr"},  16'(oOVR),      16'h0);
        chk({tag, "_to"},   16'(oTO_CNT),   16'h0);
    endtask

    // Bounded wait for a request; an expired bound is reported as a failed check.
    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (oSPI_REQ !== 1'b1 && n < 40) begin
            step();
            n = n + 1;
        end
        chk({tag, "_req_seen"}, 16'(oSPI_REQ), 16'h1);
    endtask

    // Called in the first cycle of a request; ACK lands dly cycles later.
    task automatic ack_after(input string tag, input int dly, input logic [15:0] data);
        repeat (dly) step();
        chk({tag, "_req_at_ack"}, 16'(oSPI_REQ), 16'h1);
        iSPI_ACK  = 1'b1;
        iSPI_DATA = data;
        step();
        iSPI_ACK  = 1'b0;
        iSPI_DATA = 16'h0000;
        chk({tag, "_req_drop"}, 16'(oSPI_REQ), 16'h0);
    endtask

    // Full X/Y read and publish, starting with the X request visible.
    task automatic run_seq(input string tag, input int dly, input logic [15:0] xd,
                           input logic [15:0] yd, input logic [9:0] old_dig,
                           input logic [9:0] exp_dig);
        base = falls;
        chk({tag, "_addr_x"}, 16'(oSPI_ADDR), 16'h32);
        ack_after({tag, "_x"}, dly, xd);
        chk({tag, "_busy_mid"}, 16'(oBUSY), 16'h1);
        wait_req({tag, "_y"});
        chk({tag, "_addr_y"}, 16'(oSPI_ADDR), 16'h34);
        chk({tag, "_dig_hold"}, 16'(oDIG), 16'(old_dig));
        ack_after({tag, "_y"}, dly, yd);
        // PUB cycle: strobe still high; it falls on the next edge.
        chk({tag, "_int2_pub"}, 16'(oG_INT2), 16'h1);
        chk({tag, "_dig_pub"}, 16'(oDIG), 16'(old_dig));
        step();
        chk({tag, "_int2_low0"}, 16'(oG_INT2), 16'h0);
        chk({tag, "_dig"}, 16'(oDIG), 16'(exp_dig));
        step();
        chk({tag, "_int2_low1"}, 16'(oG_INT2), 16'h0);
        step();
        chk({tag, "_int2_high"}, 16'(oG_INT2), 16'h1);
        chk({tag, "_busy_end"}, 16'(oBUSY), 16'h0);
        chk({tag, "_falls"}, 16'(falls - base), 16'h1);
    endtask

    initial begin
        iRST = 1'b1;
        step();
        step();
        chk_reset("rst0");
        iRST = 1'b0;

        // X axis published; iEN dropped once the sequence starts so it completes with no new tick.
        iEN = 1'b1;
        wait_req("a");
        iEN = 1'b0;
        run_seq("a", 2, 16'hA5C0, 16'h3FC0, 10'h000, 10'h297);
        repeat (12) step();
        chk("a_idle_req", 16'(oSPI_REQ), 16'h0);
        chk("a_idle_busy", 16'(oBUSY), 16'h0);
        chk("a_no_ovr", 16'(oOVR), 16'h0);
        chk("a_one_fall", 16'(falls - base), 16'h1);

        // Y axis published; later changes of iAXIS_SEL leave oDIG alone.
        iAXIS_SEL = 1'b1;
        iEN = 1'b1;
        wait_req("b");
        iEN = 1'b0;
        run_seq("b", 2, 16'hA5C0, 16'h3FC0, 10'h297, 10'h0FF);
        iAXIS_SEL = 1'b0;
        repeat (3) step();
        chk("b_dig_stable", 16'(oDIG), 16'h0FF);

        iRST = 1'b1;
        step();
        chk_reset("rst1");
        iRST = 1'b0;
        iEN = 1'b1;
        wait_req("c");
        base = falls;
`ifndef SAMPLE_TIMEOUT_EN
        // Withheld ACK: request holds, ticks overrun, nothing is published.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("c_req_held", 16'(oSPI_REQ), 16'h1);
        end
        chk("c_addr", 16'(oSPI_ADDR), 16'h32);
        chk("c_ovr", 16'(oOVR), 16'h1);
        chk("c_dig", 16'(oDIG), 16'h0);
        chk("c_no_fall", 16'(falls - base), 16'h0);
        chk("c_to_cnt", 16'(oTO_CNT), 16'h0);
`else
        // No ACK ever: each request is abandoned after TIMEOUT_CYC cycles.
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
            step();
            chk("d_req_held", 16'(oSPI_REQ), 16'h1);
        end
        step();
        chk("d_req_drop", 16'(oSPI_REQ), 16'h0);
        chk("d_to_one", 16'(oTO_CNT), 16'h1);
        repeat (7000) step();
        chk("d_to_sat", 16'(oTO_CNT), 16'hFF);
        chk("d_dig", 16'(oDIG), 16'h0);
        chk("d_no_fall", 16'(falls - base), 16'h0);
`endif

        // ACK while idle is ignored.
        iEN  = 1'b0;
        iRST = 1'b1;
        step();
        iRST = 1'b0;
        iSPI_ACK  = 1'b1;
        iSPI_DATA = 16'hFFC0;
        step();
        iSPI_ACK  = 1'b0;
        iSPI_DATA = 16'h0000;
        step();
        chk("e_idle_ack_busy", 16'(oBUSY), 16'h0);
        chk("e_idle_ack_req", 16'(oSPI_REQ), 16'h0);
        chk("e_idle_ack_dig", 16'(oDIG), 16'h0);

        // Reset during the Y request, then a clean sequence with first-cycle ACKs.
        iEN = 1'b1;
        wait_req("e");
        ack_after("e_x", 0, 16'hFFC0);
        wait_req("e_y");
        iRST = 1'b1;
        step();
        chk_reset("rst2");
        iRST = 1'b0;
        wait_req("f");
        iEN = 1'b0;
        run_seq("f", 0, 16'hFFC0, 16'h3FC0, 10'h000, 10'h3FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
